// File: rtl/vs4x400_pkg.sv
// vs4x400_pkg: shared constants and FSM state type for the vector search core.
package vs4x400_pkg;
    localparam int ELEM_W = 8;
    localparam int ELEMS = 8;
    localparam int VEC_W = 64;
    localparam int SCORE_W = 32;
    localparam int ADDR_W = 10;
    localparam logic [ADDR_W-1:0] QUERY_ADDR = 10'h3FF;
    localparam logic [SCORE_W-1:0] SCORE_MIN = 32'h8000_0000;
    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;
endpackage

// File: rtl/vs4x400_dot8.sv
// vs4x400_dot8: two-stage registered int8 x8 dot product (multiply, then adder tree) with valid/idx sideband.
// Ports: clk/rst, a/b 64-bit packed signed int8 vectors, in_valid/in_idx sideband in,
//        score 32-bit signed result, out_valid/out_idx sideband out, 2-cycle latency.
module vs4x400_dot8
    import vs4x400_pkg::*;
#(
    parameter int IW = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [VEC_W-1:0]   a,
    input  logic [VEC_W-1:0]   b,
    input  logic               in_valid,
    input  logic [IW-1:0]      in_idx,
    output logic [SCORE_W-1:0] score,
    output logic               out_valid,
    output logic [IW-1:0]      out_idx
);
    logic signed [15:0] prod [ELEMS];
    logic               v2;
    logic [IW-1:0]      i2;
    logic [18:0]        sum;

    always_comb begin
        sum = '0;
        for (int k = 0; k < ELEMS; k++)
            sum = sum + {{3{prod[k][15]}}, prod[k]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < ELEMS; k++)
                prod[k] <= '0;
            v2 <= 1'b0;
            i2 <= '0;
            score <= '0;
            out_valid <= 1'b0;
            out_idx <= '0;
        end else begin
            for (int k = 0; k < ELEMS; k++)
                prod[k] <= $signed(a[ELEM_W*k +: ELEM_W]) * $signed(b[ELEM_W*k +: ELEM_W]);
            v2 <= in_valid;
            i2 <= in_idx;
            score <= {{(SCORE_W-19){sum[18]}}, sum};
            out_valid <= v2;
            out_idx <= i2;
        end
    end
endmodule

// File: rtl/vs4x400_search_core.sv
// vs4x400_search_core: database of int8x8 vectors scanned against a query, reporting the best dot-product match.
// Ports: aclk, areset (async, active-high); write_addr/write_data_64/write_en load entries or the query;
//        start_search launches a scan; busy, done pulse, winner_id, max_score, no_match report the result.
module vs4x400_search_core
    import vs4x400_pkg::*;
#(
    parameter int NUM_VECTORS = 256
) (
    input  logic               aclk,
    input  logic               areset,
    input  logic [ADDR_W-1:0]  write_addr,
    input  logic [VEC_W-1:0]   write_data_64,
    input  logic               write_en,
    input  logic               start_search,
    output logic               busy,
    output logic               done,
    output logic [7:0]         winner_id,
    output logic [SCORE_W-1:0] max_score,
    output logic               no_match
);
    localparam int IW = $clog2(NUM_VECTORS);

    state_t               state, next;
    logic [VEC_W-1:0]     mem [NUM_VECTORS];
    logic [NUM_VECTORS-1:0] valid;
    logic [VEC_W-1:0]     query, rd_data;
    logic [IW-1:0]        idx, s1_idx, d_idx, best_idx;
    logic                 s1_valid, d_valid, found;
    logic [1:0]           cnt;
    logic [SCORE_W-1:0]   d_score, best;
    logic                 wr_ram, wr_query, launch, finish;

    assign busy     = state != IDLE;
    assign wr_ram   = state == IDLE && write_en && write_addr < ADDR_W'(NUM_VECTORS);
    assign wr_query = state == IDLE && write_en && write_addr == QUERY_ADDR;
    assign launch   = state == IDLE && start_search;
    assign finish   = state == DRAIN && cnt == 2'd3;

    always_comb begin
        next = state;
        case (state)
            IDLE:  next = start_search ? SCAN : IDLE;
            SCAN:  next = idx == IW'(NUM_VECTORS-1) ? DRAIN : SCAN;
            DRAIN: next = cnt == 2'd3 ? IDLE : DRAIN;
            default: next = IDLE;
        endcase
    end

    // RAM contents are deliberately not reset; only the valid bits are.
    always_ff @(posedge aclk) begin
        if (wr_ram)
            mem[write_addr[IW-1:0]] <= write_data_64;
        rd_data <= mem[idx];
    end

    vs4x400_dot8 #(.IW(IW)) u_dot8 (
        .clk(aclk), .rst(areset), .a(rd_data), .b(query),
        .in_valid(s1_valid), .in_idx(s1_idx),
        .score(d_score), .out_valid(d_valid), .out_idx(d_idx)
    );

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state <= IDLE;
            valid <= '0;
            query <= '0;
            idx <= '0;
            cnt <= '0;
            s1_valid <= 1'b0;
            s1_idx <= '0;
            best <= SCORE_MIN;
            best_idx <= '0;
            found <= 1'b0;
            done <= 1'b0;
            winner_id <= '0;
            max_score <= '0;
            no_match <= 1'b0;
        end else begin
            state <= next;
            if (wr_ram)
                valid[write_addr[IW-1:0]] <= 1'b1;
            if (wr_query)
                query <= write_data_64;
            idx <= state == SCAN ? idx + 1'b1 : '0;
            cnt <= state == DRAIN ? cnt + 2'd1 : 2'd0;
            s1_valid <= state == SCAN && valid[idx];
            s1_idx <= idx;
            // Strict greater-than keeps the lowest index on ties.
            if (launch) begin
                best <= SCORE_MIN;
                found <= 1'b0;
            end else if (d_valid && $signed(d_score) > $signed(best)) begin
                best <= d_score;
                best_idx <= d_idx;
                found <= 1'b1;
            end
            done <= finish;
            if (finish) begin
                winner_id <= found ? 8'(best_idx) : 8'd0;
                max_score <= best;
                no_match <= !found;
            end
        end
    end
endmodule

// File: tb/tb_vs4x400_search_core.sv
// tb_vs4x400_search_core: scoreboard bench for vs4x400_search_core with directed vectors.
module tb_vs4x400_search_core;
    import vs4x400_pkg::*;

    typedef struct {
        logic [7:0]  id;
        logic [31:0] score;
        logic        nm;
        int          cyc;
    } exp_t;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic [9:0]  write_addr = '0;
    logic [63:0] write_data_64 = '0;
    logic        write_en = 1'b0;
    logic        start_search = 1'b0;
    logic        busy, done, no_match;
    logic [7:0]  winner_id;
    logic [31:0] max_score;

    exp_t q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int n_done = 0;

    vs4x400_search_core dut (
        .aclk(aclk), .areset(areset), .write_addr(write_addr),
        .write_data_64(write_data_64), .write_en(write_en),
        .start_search(start_search), .busy(busy), .done(done),
        .winner_id(winner_id), .max_score(max_score), .no_match(no_match)
    );

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    function automatic logic [63:0] rep(input logic [7:0] b);
        return {8{b}};
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge aclk) begin
        if (done) begin
            n_done++;
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("winner_id", winner_id, e.id);
                check("max_score", max_score, e.score);
                check("no_match", no_match, e.nm);
                check("done_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic wr(input logic [9:0] a, input logic [63:0] d);
        write_addr = a;
        write_data_64 = d;
        write_en = 1'b1;
        tick();
        write_en = 1'b0;
    endtask

    task automatic start(input logic [7:0] id, input logic [31:0] sc, input logic nm);
        exp_t e;
        e.id = id;
        e.score = sc;
        e.nm = nm;
        e.cyc = cyc + 261;
        q.push_back(e);
        start_search = 1'b1;
        tick();
        start_search = 1'b0;
        write_en = 1'b0;
    endtask

    task automatic finish_scan(input string name, input int dones);
        int n = 0;
        while (busy && n < 400) begin
            tick();
            n++;
        end
        check({name, "_timeout"}, n >= 400, 0);
        tick();
        tick();
        check({name, "_pending"}, q.size(), 0);
        check({name, "_done_count"}, n_done, dones);
    endtask

    task automatic do_reset();
        areset = 1'b1;
        tick();
        areset = 1'b0;
        tick();
    endtask

    initial begin
        tick();
        tick();
        areset = 1'b0;
        tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_winner", winner_id, 0);
        check("rst_score", max_score, 0);
        check("rst_nm", no_match, 0);

        // empty database
        start(8'd0, 32'h8000_0000, 1'b1);
        check("busy_cycle1", busy, 1);
        finish_scan("empty", 1);

        // single entry, written in the same cycle as start
        wr(QUERY_ADDR, rep(8'h01));
        write_addr = 10'd5;
        write_data_64 = rep(8'h02);
        write_en = 1'b1;
        start(8'd5, 32'd16, 1'b0);
        finish_scan("single", 2);

        // tie between 3 and 7
        wr(10'd3, rep(8'h04));
        wr(10'd7, rep(8'h04));
        wr(10'd300, rep(8'h7F));
        start(8'd3, 32'd32, 1'b0);
        finish_scan("tie", 3);

        // signed extremes
        do_reset();
        wr(QUERY_ADDR, rep(8'h80));
        wr(10'd0, rep(8'h80));
        wr(10'd1, rep(8'h7F));
        start(8'd0, 32'd131072, 1'b0);
        finish_scan("extreme_max", 4);
        do_reset();
        wr(QUERY_ADDR, rep(8'h7F));
        wr(10'd0, rep(8'h80));
        start(8'd0, 32'hFFFE_0400, 1'b0);
        finish_scan("extreme_neg", 5);

        // busy protection
        do_reset();
        wr(QUERY_ADDR, rep(8'h01));
        wr(10'd2, rep(8'h01));
        start(8'd2, 32'd8, 1'b0);
        repeat (20) tick();
        wr(10'd9, rep(8'h7F));
        start_search = 1'b1;
        tick();
        start_search = 1'b0;
        finish_scan("busy_prot", 6);
        start(8'd2, 32'd8, 1'b0);
        finish_scan("busy_rescan", 7);

        // async reset mid-scan
        start_search = 1'b1;
        tick();
        start_search = 1'b0;
        repeat (99) tick();
        check("pre_rst_busy", busy, 1);
        #2 areset = 1'b1;
        #1;
        check("async_busy", busy, 0);
        check("async_score", max_score, 0);
        check("async_winner", winner_id, 0);
        tick();
        areset = 1'b0;
        repeat (300) tick();
        check("async_no_done", n_done, 7);
        start(8'd0, 32'h8000_0000, 1'b1);
        finish_scan("after_rst", 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
